cmos_tile_merge: RTL and testbench
==================================

# cmos_tile_merge

N-channel, single-clock line compositor that merges camera pixel streams into one stream for the frame buffer's video input port. It generalises the fixed dual-camera side-by-side merge to `NUM_CH` channels with a runtime mode (concatenate, single-select, two-channel average), per-channel line buffering, frame resynchronisation and overflow reporting. Inputs are already in the `clk` domain because upstream CDC FIFOs handle that. The output drives the frame buffer's `vin0` `vs`/`de`/`data`.

## Interface
- `NUM_CH`, default 2: channel count, range 2..8.
- `DATA_W`, default 16: pixel width, RGB565 when 16.
- `H_PIXEL`, default 640: pixels per input line.
- `FIFO_DEPTH`, default 1024: per-channel line FIFO depth. Power of 2, and must be ≥ `H_PIXEL`.
- `LINE_GAP`, default 4: minimum number of `href`-low cycles between output lines, ≥ 1.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_vsync` input, `NUM_CH` bits: per-channel frame sync, active high. Channel 0 is the master.
- `in_href` input, `NUM_CH` bits: per-channel pixel valid.
- `in_data` input, `NUM_CH*DATA_W` bits: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `mode` input, 2 bits: 0 = concat, 1 = single, 2 = average of ch0 and ch1, 3 = reserved (behaves as 0).
- `sel` input, `$clog2(NUM_CH)` bits: source channel in single mode.
- `pixel_vsync` output, 1 bit: `in_vsync[0]` delayed by one register.
- `pixel_href` output, 1 bit: output pixel valid.
- `pixel_data` output, `DATA_W` bits: output pixel.
- `overflow` output, `NUM_CH` bits: sticky per-channel FIFO-full write-drop flag.

## Operation
- **Write side.** Each channel has a line FIFO. When `in_href[k]` is high, `in_data` for channel k is pushed.
  - If that FIFO is full, the pixel is dropped and `overflow[k]` is set.
  - Each FIFO has a registered fill count of width `$clog2(FIFO_DEPTH)+1`.
- **Frame sync.** On a rising edge of `in_vsync[0]` (detected against a registered copy):
  - all FIFOs are flushed synchronously, which zeroes pointers and counts;
  - writes in the flush cycle are discarded;
  - `overflow` is cleared;
  - the FSM goes to IDLE.
  - This takes priority over every other event, including mid-line, where `pixel_href` drops on the next cycle.
- **FSM: IDLE → LINE → GAP → IDLE.**
  - IDLE: wait until every channel's count ≥ `H_PIXEL`. Then latch `mode` and `sel` (line-stable) and enter LINE.
  - LINE, concat: `NUM_CH*H_PIXEL` read cycles. Read `ch_idx` = 0..`NUM_CH-1`, `H_PIXEL` pixels each, output in that order.
  - LINE, single and average: `H_PIXEL` read cycles. All FIFOs are popped in parallel so every channel stays line-aligned.
    - Single outputs channel `sel`. An out-of-range `sel` is treated as 0.
    - Average outputs `{(R0+R1)>>1, (G0+G1)>>1, (B0+B1)>>1}` per 5/6/5 field, computed at full width then truncated. For `DATA_W`≠16, the plain `(a+b)>>1` over `DATA_W+1` bits is used.
  - GAP: `LINE_GAP` cycles with `href` low, then IDLE.
- A FIFO is never read when empty; the entry condition guarantees this. Simultaneous push and pop on the same FIFO is legal and leaves the count unchanged.

## Timing
- Reset values: `pixel_vsync`=0, `pixel_href`=0, `pixel_data`=0, `overflow`=0, FSM=IDLE, all FIFOs empty.
- Latency: take the write whose `clk` edge makes the last channel's count reach `H_PIXEL` as edge t.
  - count visible at t+1;
  - LINE entered with first read at t+2;
  - first `pixel_href`/`pixel_data` registered at t+3.
- `pixel_href` is continuously high for exactly the line length (`NUM_CH*H_PIXEL` or `H_PIXEL`), with no bubbles.
- `pixel_data` is held at its last value while `href` is low.
- Back-to-back lines are separated by at least `LINE_GAP` low cycles.
- `pixel_vsync` has a latency of 1 cycle from `in_vsync[0]`. `in_vsync[1..]` are ignored, apart from being documented as expected to be frame-aligned.

## Structure
- Shared package `cmos_merge_pkg`:
  - mode constants `MODE_CONCAT`=0, `MODE_SINGLE`=1, `MODE_AVG`=2;
  - FSM state enum `{ST_IDLE, ST_LINE, ST_GAP}`;
  - the RGB565 field-average function.
- Sub-module `line_fifo_sc`: a single-clock FIFO with parameters `DATA_W` and `DEPTH`, a synchronous flush, a registered count, and registered read data. Instantiate it `NUM_CH` times with generate.

## Test plan
- **Concat.** `NUM_CH`=2, `H_PIXEL`=8, mode 0. ch0 sends 0x0001..0x0008 and ch1 sends 0x0101..0x0108, simultaneously. Expected: 16 contiguous `href` cycles carrying ch0's pixels then ch1's, with the first pixel exactly 3 cycles after the 8th write.
- **Single and skew.** Mode 1, `sel`=1, ch1 lagging ch0 by 5 cycles. Expected: 8-pixel line of 0x0101..0x0108 starting 3 cycles after ch1's 8th write; a subsequent line's FIFOs stay aligned.
- **Average.** Mode 2, ch0=0xF800 and ch1=0x0800 for all pixels. Expected: every output pixel is 0x8000; a 0xFFFF/0xFFFF pair gives 0xFFFF.
- **Overflow.** `FIFO_DEPTH`=16, `H_PIXEL`=8, ch1 `href` held low while ch0 writes 20 pixels. Expected: `overflow`=2'b01 after the 17th write, no output line, and `overflow` cleared on the next `in_vsync[0]` rise.
- **Mid-line resync.** Raise `in_vsync[0]` during the 4th output pixel. Expected: `href` low the next cycle, all counts 0, and the next line is emitted correctly from fresh data.
- **Reset and gap.** `rst_n` asserted mid-line: outputs are 0 immediately. Two consecutive ready lines: exactly `LINE_GAP`=4 low cycles between them.

Source files
------------

// File: rtl/cmos_merge_pkg.sv
// Shared types and helpers for the multi-camera line compositor.
package cmos_merge_pkg;

    localparam logic [1:0] MODE_CONCAT = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_AVG    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_GAP
    } state_t;

    // Per-field mean of two RGB565 pixels; each sum is one bit wider.
    function automatic logic [15:0] avg565(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [5:0] r;
        logic [6:0] g;
        logic [5:0] bl;
        r  = {1'b0, a[15:11]} + {1'b0, b[15:11]};
        g  = {1'b0, a[10:5]}  + {1'b0, b[10:5]};
        bl = {1'b0, a[4:0]}   + {1'b0, b[4:0]};
        return {r[5:1], g[6:1], bl[5:1]};
    endfunction

endpackage

// File: rtl/line_fifo_sc.sv
// Single-clock line FIFO with synchronous flush, registered count
// and registered read data.
module line_fifo_sc #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we;
    logic              re;

    assign full_o = (cnt_q == CW'(DEPTH));
    assign we     = wr_en_i & ~full_o & ~flush_i;
    assign re     = rd_en_i & (cnt_q != '0) & ~flush_i;

    always_ff @(posedge clk) begin
        if (we) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (we) wptr_q <= wptr_q + AW'(1);
            if (re) begin
                rptr_q  <= rptr_q + AW'(1);
                rdata_q <= mem_q[rptr_q];
            end
            cnt_q <= cnt_q + CW'(we) - CW'(re);
        end
    end

    assign rd_data_o = rdata_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/cmos_tile_merge.sv
// N-channel camera line compositor: concat, single-select or
// two-channel average into one pixel stream.
module cmos_tile_merge
    import cmos_merge_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int H_PIXEL    = 640,
    parameter int FIFO_DEPTH = 1024,
    parameter int LINE_GAP   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_vsync,
    input  logic [NUM_CH-1:0]          in_href,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [1:0]                 mode,
    input  logic [$clog2(NUM_CH)-1:0]  sel,
    output logic                       pixel_vsync,
    output logic                       pixel_href,
    output logic [DATA_W-1:0]          pixel_data,
    output logic [NUM_CH-1:0]          overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(NUM_CH);
    localparam int PW = $clog2(H_PIXEL + 1);
    localparam int GW = $clog2(LINE_GAP + 1);

    logic              vs_q;
    logic              flush;
    logic [NUM_CH-1:0] rd_en;
    logic [NUM_CH-1:0] full;
    logic [CW-1:0]     cnt [NUM_CH];
    logic [DATA_W-1:0] rd_data [NUM_CH];
    logic              all_ready;
    logic              start;
    logic              last_pix;
    logic              last_ch;
    logic              gap_done;
    state_t            state_q, state_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [SW-1:0]     ch_q, ch_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [SW-1:0]     sel_in;
    logic [SW-1:0]     rd_src, src_q;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        mode_in;
    logic [GW-1:0]     gap_q, gap_d;
    logic              rd_valid_q;
    logic              href_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] out_pix;
    logic [DATA_W-1:0] avg_pix;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              unused_vs;

    assign unused_vs = ^in_vsync[NUM_CH-1:1];
    assign flush     = in_vsync[0] & ~vs_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        line_fifo_sc #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush),
            .wr_en_i   (in_href[k]),
            .wr_data_i (in_data[k*DATA_W +: DATA_W]),
            .rd_en_i   (rd_en[k]),
            .rd_data_o (rd_data[k]),
            .count_o   (cnt[k]),
            .full_o    (full[k])
        );
    end

    always_comb begin
        all_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt[k] < CW'(H_PIXEL)) all_ready = 1'b0;
        end
    end

    assign mode_in = (mode == 2'd3) ? MODE_CONCAT : mode;

    if (NUM_CH == (1 << SW)) begin : g_sel_full
        assign sel_in = sel;
    end else begin : g_sel_clip
        assign sel_in = (sel < SW'(NUM_CH)) ? sel : '0;
    end

    assign last_pix = (pix_q == PW'(H_PIXEL - 1));
    assign last_ch  = (ch_q == SW'(NUM_CH - 1));
    assign gap_done = (gap_q == GW'(LINE_GAP - 1));

    // A ready line may start straight out of the last gap cycle so that
    // back-to-back lines are separated by exactly LINE_GAP idle cycles.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        ch_d    = ch_q;
        gap_d   = gap_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        rd_en   = '0;
        rd_src  = ch_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: start = all_ready;
            ST_LINE: begin
                if (mode_q == MODE_CONCAT) begin
                    rd_en[ch_q] = 1'b1;
                end else begin
                    rd_en  = '1;
                    rd_src = sel_q;
                end
                pix_d = last_pix ? '0 : pix_q + PW'(1);
                if (last_pix) begin
                    if (mode_q != MODE_CONCAT || last_ch) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        ch_d = ch_q + SW'(1);
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_done) begin
                    state_d = ST_IDLE;
                    start   = all_ready;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_LINE;
            mode_d  = mode_in;
            sel_d   = sel_in;
            pix_d   = '0;
            ch_d    = '0;
        end
        if (flush) begin
            state_d = ST_IDLE;
            rd_en   = '0;
        end
    end

    if (DATA_W == 16) begin : g_avg565
        assign avg_pix = avg565(rd_data[0], rd_data[1]);
    end else begin : g_avg_lin
        logic [DATA_W:0] sum;
        assign sum     = {1'b0, rd_data[0]} + {1'b0, rd_data[1]};
        assign avg_pix = sum[DATA_W:1];
    end

    assign out_pix = (mode_q == MODE_AVG) ? avg_pix : rd_data[src_q];
    assign ovf_d   = flush ? '0 : (ovf_q | (in_href & full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            ch_q       <= '0;
            gap_q      <= '0;
            mode_q     <= MODE_CONCAT;
            sel_q      <= '0;
            vs_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            src_q      <= '0;
            href_q     <= 1'b0;
            data_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            ch_q       <= ch_d;
            gap_q      <= gap_d;
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            vs_q       <= in_vsync[0];
            rd_valid_q <= |rd_en;
            src_q      <= rd_src;
            href_q     <= rd_valid_q & ~flush;
            ovf_q      <= ovf_d;
            if (rd_valid_q && !flush) data_q <= out_pix;
        end
    end

    assign pixel_vsync = vs_q;
    assign pixel_href  = href_q;
    assign pixel_data  = data_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cmos_tile_merge.sv
// Self-checking bench for cmos_tile_merge: vector table, random lines
// against a reference model, and hand-written corner sequences.
module tb_cmos_tile_merge;

    localparam int NC = 2;
    localparam int DW = 16;
    localparam int HP = 8;
    localparam int FD = 16;
    localparam int LG = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   in_vsync;
    logic [NC-1:0]   in_href;
    logic [NC*DW-1:0] in_data;
    logic [1:0]      mode;
    logic            sel;
    logic            pixel_vsync;
    logic            pixel_href;
    logic [DW-1:0]   pixel_data;
    logic [NC-1:0]   overflow;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } ev_t;

    typedef struct {
        int          md;
        int          sl;
        int          sk;
        logic [15:0] b0;
        logic [15:0] b1;
        int          inc;
        int          elen;
        logic [15:0] efirst;
        logic [15:0] elast;
    } vec_t;

    ev_t         obs[$];
    ev_t         exp_q[$];
    ev_t         mon_ev;
    logic [15:0] pd [2][16];
    int          tw [2][16];
    vec_t        vt [7];

    cmos_tile_merge #(
        .NUM_CH     (NC),
        .DATA_W     (DW),
        .H_PIXEL    (HP),
        .FIFO_DEPTH (FD),
        .LINE_GAP   (LG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vsync    (in_vsync),
        .in_href     (in_href),
        .in_data     (in_data),
        .mode        (mode),
        .sel         (sel),
        .pixel_vsync (pixel_vsync),
        .pixel_href  (pixel_href),
        .pixel_data  (pixel_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && pixel_href === 1'b1) begin
            mon_ev.cyc = cyc;
            mon_ev.d   = pixel_data;
            obs.push_back(mon_ev);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input int c, input logic [15:0] d);
        ev_t e;
        e.cyc = c;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] avg_ref(input int a, input int b);
        int r, g, bb;
        r  = (a / 2048 + b / 2048) / 2;
        g  = ((a / 32) % 64 + (b / 32) % 64) / 2;
        bb = (a % 32 + b % 32) / 2;
        return 16'(r * 2048 + g * 32 + bb);
    endfunction

    task automatic model_line(input int md, input int sl,
                              input int ib, input int st);
        if (md == 1) begin
            for (int i = 0; i < HP; i++) add_exp(st + i, pd[sl][ib + i]);
        end else if (md == 2) begin
            for (int i = 0; i < HP; i++)
                add_exp(st + i, avg_ref(pd[0][ib + i], pd[1][ib + i]));
        end else begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < HP; i++)
                    add_exp(st + k * HP + i, pd[k][ib + i]);
        end
    endtask

    task automatic sched(input int k, input int n, input int st,
                         input int gmax);
        int t;
        t = st;
        for (int i = 0; i < n; i++) begin
            tw[k][i] = t;
            t += 1 + $urandom_range(0, gmax);
        end
    endtask

    task automatic drive(input int n0, input int n1, output int le);
        int idx [2];
        int nn  [2];
        int c;
        idx[0] = 0;
        idx[1] = 0;
        nn[0]  = n0;
        nn[1]  = n1;
        c      = 0;
        le     = cyc;
        while (idx[0] < n0 || idx[1] < n1) begin
            for (int k = 0; k < 2; k++) begin
                in_href[k] = 1'b0;
                if (idx[k] < nn[k] && tw[k][idx[k]] == c) begin
                    in_href[k]          = 1'b1;
                    in_data[k*16 +: 16] = pd[k][idx[k]];
                    idx[k]++;
                    le = cyc + 1;
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_href = '0;
    endtask

    task automatic check_line(input string nm);
        int w;
        w = 0;
        while (obs.size() < exp_q.size() && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk({nm, " len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk({nm, " cyc"}, obs[i].cyc, exp_q[i].cyc);
            chk({nm, " px"}, obs[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        int le;
        int w;
        rst_n    = 1'b0;
        in_vsync = '0;
        in_href  = '0;
        in_data  = '0;
        mode     = 2'd0;
        sel      = 1'b0;

        vt[0] = '{0, 0, 0, 16'h0001, 16'h0101, 1, 16, 16'h0001, 16'h0108};
        vt[1] = '{1, 1, 5, 16'h0001, 16'h0101, 1, 8, 16'h0101, 16'h0108};
        vt[2] = '{1, 1, 0, 16'h0001, 16'h0101, 1, 8, 16'h0101, 16'h0108};
        vt[3] = '{1, 0, -3, 16'h0001, 16'h0101, 1, 8, 16'h0001, 16'h0008};
        vt[4] = '{2, 0, 0, 16'hF800, 16'h0800, 0, 8, 16'h8000, 16'h8000};
        vt[5] = '{2, 1, 2, 16'hFFFF, 16'hFFFF, 0, 8, 16'hFFFF, 16'hFFFF};
        vt[6] = '{3, 0, 1, 16'h0A00, 16'h0B00, 1, 16, 16'h0A00, 16'h0B07};

        idle(3);
        chk("rst vsync", pixel_vsync, 0);
        chk("rst href", pixel_href, 0);
        chk("rst data", pixel_data, 0);
        chk("rst ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int v = 0; v < 7; v++) begin
            mode = 2'(vt[v].md);
            sel  = vt[v].sl[0];
            for (int i = 0; i < HP; i++) begin
                pd[0][i] = vt[v].b0 + 16'(vt[v].inc * i);
                pd[1][i] = vt[v].b1 + 16'(vt[v].inc * i);
            end
            sched(0, HP, vt[v].sk < 0 ? -vt[v].sk : 0, 0);
            sched(1, HP, vt[v].sk > 0 ? vt[v].sk : 0, 0);
            drive(HP, HP, le);
            exp_q.delete();
            model_line(vt[v].md, vt[v].sl, 0, le + 3);
            check_line($sformatf("vec%0d", v));
            chk($sformatf("vec%0d tlen", v), obs.size(), vt[v].elen);
            if (obs.size() > 0) begin
                chk($sformatf("vec%0d first", v), obs[0].d, vt[v].efirst);
                chk($sformatf("vec%0d last", v), obs[$].d, vt[v].elast);
            end
            obs.delete();
            idle(8);
        end

        for (int r = 0; r < 8; r++) begin
            int md, sl;
            md   = $urandom_range(0, 3);
            sl   = $urandom_range(0, 1);
            mode = 2'(md);
            sel  = 1'(sl);
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < HP; i++) pd[k][i] = 16'($urandom);
            sched(0, HP, $urandom_range(0, 4), 2);
            sched(1, HP, $urandom_range(0, 4), 2);
            drive(HP, HP, le);
            exp_q.delete();
            model_line(md, sl, 0, le + 3);
            check_line($sformatf("rand%0d", r));
            obs.delete();
            idle(8);
        end

        mode = 2'd1;
        sel  = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) pd[k][i] = 16'($urandom);
        sched(0, 16, 0, 0);
        sched(1, 16, 0, 0);
        drive(16, 16, le);
        exp_q.delete();
        model_line(1, 0, 0, le - 8 + 3);
        model_line(1, 0, 8, le - 8 + 3 + HP + LG);
        check_line("gap");
        if (obs.size() >= 9)
            chk("gap low", obs[8].cyc - obs[7].cyc - 1, LG);
        obs.delete();
        idle(8);

        for (int i = 0; i < 20; i++) begin
            in_href      = 2'b01;
            in_data[15:0] = 16'(i + 1);
            @(posedge clk);
            #1;
            if (i == 15) chk("ovf at 16", overflow, 2'b00);
            if (i == 16) chk("ovf at 17", overflow, 2'b01);
        end
        in_href = '0;
        idle(20);
        chk("ovf no line", obs.size(), 0);
        chk("ovf sticky", overflow, 2'b01);
        in_vsync = 2'b11;
        idle(1);
        chk("ovf clear", overflow, 2'b00);
        chk("vsync rise", pixel_vsync, 1);
        idle(3);
        in_vsync = 2'b00;
        idle(1);
        chk("vsync fall", pixel_vsync, 0);
        obs.delete();
        idle(5);

        mode = 2'd0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < HP; i++) pd[k][i] = 16'($urandom);
        sched(0, HP, 0, 0);
        sched(1, HP, 0, 0);
        drive(HP, HP, le);
        exp_q.delete();
        model_line(0, 0, 0, le + 3);
        w = 0;
        while (obs.size() < 4 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        in_vsync = 2'b11;
        idle(1);
        chk("resync href", pixel_href, 0);
        chk("resync vsync", pixel_vsync, 1);
        idle(5);
        chk("resync cnt", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            chk("resync cyc", obs[i].cyc, exp_q[i].cyc);
            chk("resync px", obs[i].d, exp_q[i].d);
        end
        in_vsync = 2'b00;
        obs.delete();
        idle(6);

        mode = 2'd1;
        sel  = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < HP; i++) pd[k][i] = 16'($urandom);
        sched(0, HP, 0, 1);
        sched(1, HP, 1, 1);
        drive(HP, HP, le);
        exp_q.delete();
        model_line(1, 1, 0, le + 3);
        check_line("post resync");
        obs.delete();
        idle(8);

        mode = 2'd0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < HP; i++)
                pd[k][i] = 16'($urandom) | 16'h0001;
        sched(0, HP, 0, 0);
        sched(1, HP, 0, 0);
        drive(HP, HP, le);
        w = 0;
        while (obs.size() < 3 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst href", pixel_href, 0);
        chk("midrst data", pixel_data, 0);
        chk("midrst vsync", pixel_vsync, 0);
        chk("midrst ovf", overflow, 0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        idle(3);

        mode = 2'd2;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < HP; i++) pd[k][i] = 16'($urandom);
        sched(0, HP, 0, 0);
        sched(1, HP, 2, 0);
        drive(HP, HP, le);
        exp_q.delete();
        model_line(2, 0, 0, le + 3);
        check_line("post reset");
        obs.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
